// File: rtl/keypad_entry_display_pkg.sv
// Shared key codes and the digit-to-seven-segment encoding used by the keypad entry display.
package keypad_entry_display_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/keypad_entry_display_key_debounce.sv
// Two-flop synchronizer plus one-shot debouncer: emits one key code pulse per clean press,
// then waits for a clean all-released interval before it will accept another key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] keypad_in,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [11:0]   sync1;
    logic [11:0]   sync2;
    logic [11:0]   sample;
    logic [RW-1:0] run;
    logic          armed;
    logic          stable;
    logic          one_hot;
    logic          idle;

    function automatic logic [3:0] onehot_to_code(input logic [11:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) c = 4'(i);
        end
        return c;
    endfunction

    // run counts how many consecutive cycles sample has held its current value (saturating).
    assign stable  = (run == RW'(DEBOUNCE_CYCLES));
    assign one_hot = (sample != 12'd0) && ((sample & (sample - 12'd1)) == 12'd0);
    assign idle    = (sample == 12'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            sample    <= '0;
            run       <= '0;
            armed     <= 1'b1;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the flop chain shift one stage per clock.
            sync1 <= keypad_in;
            sync2 <= sync1;
            sample <= sync2;
            if (sync2 != sample) begin
                run <= RW'(1);
            end else if (!stable) begin
                run <= run + 1'b1;
            end

            key_valid <= 1'b0;
            if (armed && stable && one_hot) begin
                key_valid <= 1'b1;
                key_code  <= onehot_to_code(sample);
                armed     <= 1'b0;
            end else if (!armed && stable && idle) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_display.sv
// Keypad digit entry buffer with backspace/clear and a time-multiplexed seven-segment display.
module keypad_entry_display
    import keypad_entry_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SCAN_DIV        = 5000,
    parameter int OVERFLOW_MODE   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [11:0]                       keypad_in,
    output logic [6:0]                        seg_display,
    output logic [NUM_DIGITS-1:0]             array_en,
    output logic                              key_valid,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              full
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [3:0]    key_code;
    logic [3:0]    digits [NUM_DIGITS];
    logic [CW-1:0] count;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic [6:0]    seg_next;
    logic          at_max;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk      (clk),
        .rst      (rst),
        .keypad_in(keypad_in),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    assign at_max      = (count == CW'(NUM_DIGITS));
    assign full        = at_max;
    assign digit_count = count;

    // Position 0 is the newest digit; backspace pulls everything down one slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the buffer is reset explicitly so cleared positions always read back as 0.
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
            count <= '0;
        end else if (key_valid) begin
            if (key_code == KEY_HASH) begin
                for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
                count <= '0;
            end else if (key_code == KEY_STAR) begin
                if (count != '0) begin
                    for (int i = 0; i < NUM_DIGITS - 1; i++) digits[i] <= digits[i+1];
                    digits[NUM_DIGITS-1] <= 4'd0;
                    count <= count - 1'b1;
                end
            end else if (!at_max || OVERFLOW_MODE == 1) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) digits[i] <= digits[i-1];
                digits[0] <= key_code;
                if (!at_max) count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns seg_next and no latch is inferred.
        seg_next = 7'b0000000;
        if (CW'(scan_idx) < count) seg_next = seg7(digits[scan_idx]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt    <= '0;
            scan_idx    <= '0;
            array_en    <= '1;
            seg_display <= 7'b0000000;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            array_en    <= ~(EN_ONE << scan_idx);
            seg_display <= seg_next;
        end
    end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display: two instances (drop-new and discard-oldest overflow)
// with NUM_DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_DIV=2 sharing clock, reset and keypad input.
module tb_keypad_entry_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] keypad_in;
    logic [6:0]  seg0, seg1;
    logic [3:0]  en0, en1;
    logic        kv0, kv1;
    logic [2:0]  cnt0, cnt1;
    logic        full0, full1;

    int checks = 0;
    int errors = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    keypad_entry_display #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .OVERFLOW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .keypad_in(keypad_in), .seg_display(seg0), .array_en(en0),
        .key_valid(kv0), .digit_count(cnt0), .full(full0));

    keypad_entry_display #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .OVERFLOW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .keypad_in(keypad_in), .seg_display(seg1), .array_en(en1),
        .key_valid(kv1), .digit_count(cnt1), .full(full1));

    always @(negedge clk) begin
        if (kv0) pulses0++;
        if (kv1) pulses1++;
    end

    task automatic drive(input logic [11:0] pattern, input int hold);
        @(negedge clk) keypad_in = pattern;
        repeat (hold) @(negedge clk);
        keypad_in = 12'd0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press(input int k);
        drive(12'd1 << k, 8);
    endtask

    // Returns X on timeout so the caller's comparison fails.
    task automatic read_seg(input bit which, input int pos, output logic [6:0] seg);
        logic [3:0] want;
        bit found;
        want = ~(4'b0001 << pos);
        seg = 'x;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!which && en0 == want) begin seg = seg0; found = 1; end
            if (which && en1 == want) begin seg = seg1; found = 1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        keypad_in = 12'd0;
        repeat (3) @(negedge clk);
        checks++; if (en0 !== 4'hF) begin errors++; $display("FAIL reset_en got %b want 1111", en0); end
        checks++; if (seg0 !== 7'd0) begin errors++; $display("FAIL reset_seg got %b want 0000000", seg0); end
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full0); end
        checks++; if (kv0 !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", kv0); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_key();
        int p0;
        logic [6:0] s;
        p0 = pulses0;
        drive(12'd1 << 5, 10);
        checks++; if (pulses0 - p0 != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses0 - p0); end
        checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", cnt0); end
        read_seg(0, 0, s);
        checks++; if (s !== 7'b1101101) begin errors++; $display("FAIL single_digit0 got %b want 1101101", s); end
        read_seg(0, 1, s);
        checks++; if (s !== 7'd0) begin errors++; $display("FAIL single_digit1_blank got %b want 0000000", s); end
    endtask

    task automatic test_fill_overflow();
        int p0;
        logic [6:0] s;
        int exp0 [4] = '{4, 3, 2, 1};
        int exp1 [4] = '{5, 4, 3, 2};
        press(11);
        checks++; if (cnt0 !== 3'd0 || cnt1 !== 3'd0) begin
            errors++; $display("FAIL fill_clear got %0d/%0d want 0/0", cnt0, cnt1); end
        p0 = pulses0;
        for (int k = 1; k <= 5; k++) press(k);
        checks++; if (pulses0 - p0 != 5) begin errors++; $display("FAIL fill_pulses got %0d want 5", pulses0 - p0); end
        checks++; if (cnt0 !== 3'd4 || full0 !== 1'b1) begin
            errors++; $display("FAIL fill_drop_count got %0d full %b want 4 full 1", cnt0, full0); end
        checks++; if (cnt1 !== 3'd4 || full1 !== 1'b1) begin
            errors++; $display("FAIL fill_shift_count got %0d full %b want 4 full 1", cnt1, full1); end
        for (int p = 0; p < 4; p++) begin
            read_seg(0, p, s);
            checks++; if (s !== seg_tab[exp0[p]]) begin
                errors++; $display("FAIL fill_drop_pos%0d got %b want %b", p, s, seg_tab[exp0[p]]); end
            read_seg(1, p, s);
            checks++; if (s !== seg_tab[exp1[p]]) begin
                errors++; $display("FAIL fill_shift_pos%0d got %b want %b", p, s, seg_tab[exp1[p]]); end
        end
    endtask

    task automatic test_multibit_and_edit();
        int p0;
        logic [6:0] s;
        press(11);
        p0 = pulses0;
        drive(12'h003, 10);
        checks++; if (pulses0 - p0 != 0) begin errors++; $display("FAIL multibit_pulses got %0d want 0", pulses0 - p0); end
        press(10);
        checks++; if (pulses0 - p0 != 1) begin errors++; $display("FAIL star_empty_pulse got %0d want 1", pulses0 - p0); end
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL star_empty_count got %0d want 0", cnt0); end
        for (int k = 1; k <= 3; k++) press(k);
        checks++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL edit_count got %0d want 3", cnt0); end
        press(10);
        checks++; if (cnt0 !== 3'd2) begin errors++; $display("FAIL star_count got %0d want 2", cnt0); end
        read_seg(0, 0, s);
        checks++; if (s !== seg_tab[2]) begin errors++; $display("FAIL star_pos0 got %b want %b", s, seg_tab[2]); end
        read_seg(0, 1, s);
        checks++; if (s !== seg_tab[1]) begin errors++; $display("FAIL star_pos1 got %b want %b", s, seg_tab[1]); end
        read_seg(0, 2, s);
        checks++; if (s !== 7'd0) begin errors++; $display("FAIL star_pos2_blank got %b want 0000000", s); end
        press(11);
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL hash_count got %0d want 0", cnt0); end
        for (int p = 0; p < 4; p++) begin
            read_seg(0, p, s);
            checks++; if (s !== 7'd0) begin errors++; $display("FAIL hash_blank_pos%0d got %b want 0000000", p, s); end
        end
    endtask

    task automatic test_bounce();
        int p0;
        logic [6:0] s;
        press(11);
        p0 = pulses0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) keypad_in = (i % 2 == 0) ? (12'd1 << 7) : 12'd0;
            @(negedge clk);
        end
        @(negedge clk) keypad_in = 12'd1 << 7;
        repeat (5) @(negedge clk);
        keypad_in = 12'd0;
        checks++; if (pulses0 - p0 != 0) begin errors++; $display("FAIL bounce_early got %0d want 0", pulses0 - p0); end
        repeat (10) @(negedge clk);
        checks++; if (pulses0 - p0 != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", pulses0 - p0); end
        checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL bounce_count got %0d want 1", cnt0); end
        read_seg(0, 0, s);
        checks++; if (s !== seg_tab[7]) begin errors++; $display("FAIL bounce_digit got %b want %b", s, seg_tab[7]); end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] want;
        bit found;
        found = 0;
        prev = en0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (en0 == 4'b1110 && prev != 4'b1110) found = 1;
            prev = en0;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL scan_start got %b want 1110 within 40 cycles", en0);
        end else begin
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                want = ~(4'b0001 << ((j / 2) % 4));
                checks++; if (en0 !== want) begin errors++; $display("FAIL scan_step%0d got %b want %b", j, en0, want); end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        p0 = pulses0;
        @(negedge clk) keypad_in = 12'd1 << 3;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (en0 !== 4'hF || en1 !== 4'hF) begin
            errors++; $display("FAIL midreset_en got %b/%b want 1111/1111", en0, en1); end
        checks++; if (seg0 !== 7'd0 || cnt0 !== 3'd0 || full0 !== 1'b0 || kv0 !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got seg %b cnt %0d full %b kv %b want 0/0/0/0", seg0, cnt0, full0, kv0); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        keypad_in = 12'd0;
        repeat (12) @(negedge clk);
        checks++; if (pulses0 - p0 != 0) begin errors++; $display("FAIL midreset_pulses got %0d want 0", pulses0 - p0); end
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", cnt0); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_fill_overflow();
        test_multibit_and_edit();
        test_bounce();
        test_scan();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
